// File: rtl/fetch_pc_seq.sv
// F-stage program counter with req/gnt fetch handshake and prioritised redirects.
// Optional build macro FETCH_PC_ALIGN_TRAP_EN enables range/alignment fault checking of the fetch PC.
module fetch_pc_seq #(
    parameter int unsigned          ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC   = 32'h0000_3000,
    parameter logic [ADDR_W-1:0]    HANDLER_VEC = 32'h0000_4180,
    parameter logic [ADDR_W-1:0]    TEXT_LO     = 32'h0000_3000,
    parameter logic [ADDR_W-1:0]    TEXT_HI     = 32'h0000_6ffc,
    parameter int unsigned          STEP        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [4:0]        exc_code
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

    localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_v_q, pend_v_d;
    logic [1:0]        pend_pri_q, pend_pri_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    logic              redir;
    logic [1:0]        redir_pri;
    logic [ADDR_W-1:0] redir_tgt;
    logic              fault;
    logic              done;

    // Redirect priority: 3 = exception, 2 = ERET, 1 = branch/jump, 0 = none
    always_comb begin
        redir     = exc_req | eret_req | br_valid;
        redir_pri = 2'd0;
        redir_tgt = br_target;
        if (exc_req) begin
            redir_pri = 2'd3;
            redir_tgt = HANDLER_VEC;
        end else if (eret_req) begin
            redir_pri = 2'd2;
            redir_tgt = epc;
        end else if (br_valid) begin
            redir_pri = 2'd1;
        end
    end

`ifdef FETCH_PC_ALIGN_TRAP_EN
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);
    logic pc_illegal;

    always_comb begin
        pc_illegal = (pc_q < TEXT_LO) || (pc_q > TEXT_HI) || ((pc_q & STEP_MASK) != '0);
        fault      = (state_q == S_FETCH) && pc_illegal;
        exc_code   = fault ? 5'd4 : 5'd0;
    end
`else
    always_comb begin
        fault    = 1'b0;
        exc_code = '0;
    end
`endif

    always_comb begin
        done      = (state_q == S_FETCH) && (imem_gnt || fault);
        imem_req  = (state_q == S_FETCH) && !fault;
        imem_addr = pc_q;
        pc        = pc_q;
        pc_valid  = done;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_v_d   = pend_v_q;
        pend_pri_d = pend_pri_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redir) begin
                    pc_d     = redir_tgt;
                    pend_v_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (done) begin
                    if (redir)
                        pc_d = redir_tgt;
                    else if (pend_v_q)
                        pc_d = pend_tgt_q;
                    else
                        pc_d = pc_q + STEP_INC;
                    pend_v_d = 1'b0;
                    state_d  = en ? S_FETCH : S_HOLD;
                end else if (redir && (!pend_v_q || redir_pri >= pend_pri_q)) begin
                    // Request outstanding: address must stay put, so park the redirect
                    pend_v_d   = 1'b1;
                    pend_pri_d = redir_pri;
                    pend_tgt_d = redir_tgt;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d     = redir_tgt;
                    pend_v_d = 1'b0;
                end
                if (en)
                    state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_VEC;
            pend_v_q   <= 1'b0;
            pend_pri_q <= '0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_pri_q <= pend_pri_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule
